sseg_scan_decoder: RTL and testbench

- Reads the multiplexed seven-segment bus (active-low anodes, active-low segments) that the display drivers produce, and reconstructs the four displayed characters.
- Each digit is captured only after its anode/segment pair has been stable for a programmable dwell, so scan transitions and ghosting are ignored.
- Lets benches and on-chip self-checks read back stopwatch and counter displays as hex values instead of raw segment patterns.

---
 rtl/sseg_scan_decoder.sv | 185 ++++++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_decoder.sv
// Recovers four hex digits from a multiplexed active-low seven-segment bus,
// capturing each anode/segment pair only after it has been stable for a dwell.
// Optional: define SSEG_SQUARE_DECODE_EN to decode the upper/lower square glyphs.
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  an_i,
  input  logic [6:0]  sseg_i,
  input  logic        clr_err_i,
  output logic [15:0] digits_o,
  output logic [3:0]  blank_o,
  output logic [7:0]  sq_o,
  output logic        frame_o,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

  logic [3:0]       an_q;
  logic [6:0]       sseg_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [3:0]       seen_q, seen_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       blank_q, blank_d;
  logic             frame_q, frame_d;
  logic             err_q, err_d;
`ifdef SSEG_SQUARE_DECODE_EN
  logic [7:0]       sq_q, sq_d;
`endif

  logic       pair_same;
  logic       cap;
  logic [1:0] dig_k;
  logic       one_lit;
  logic [4:0] hex;
  logic       mark;
  logic [3:0] seen_nx;

  // Returns {valid, value}; patterns are active-low gfedcba.
  function automatic logic [4:0] hex_decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: hex_decode = {1'b1, 4'h0};
      7'b1111001: hex_decode = {1'b1, 4'h1};
      7'b0100100: hex_decode = {1'b1, 4'h2};
      7'b0110000: hex_decode = {1'b1, 4'h3};
      7'b0011001: hex_decode = {1'b1, 4'h4};
      7'b0010010: hex_decode = {1'b1, 4'h5};
      7'b0000010: hex_decode = {1'b1, 4'h6};
      7'b1111000: hex_decode = {1'b1, 4'h7};
      7'b0000000: hex_decode = {1'b1, 4'h8};
      7'b0010000: hex_decode = {1'b1, 4'h9};
      7'b0001000: hex_decode = {1'b1, 4'hA};
      7'b0000011: hex_decode = {1'b1, 4'hB};
      7'b1000110: hex_decode = {1'b1, 4'hC};
      7'b0100001: hex_decode = {1'b1, 4'hD};
      7'b0000110: hex_decode = {1'b1, 4'hE};
      7'b0001110: hex_decode = {1'b1, 4'hF};
      default:    hex_decode = 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    pair_same = ({an_i, sseg_i} == {an_q, sseg_q});
    cap       = (cnt_q == CNT_CAP) && pair_same && !done_q;
    hex       = hex_decode(sseg_q);

    one_lit = 1'b1;
    dig_k   = 2'd0;
    case (an_q)
      4'b1110: dig_k = 2'd0;
      4'b1101: dig_k = 2'd1;
      4'b1011: dig_k = 2'd2;
      4'b0111: dig_k = 2'd3;
      default: one_lit = 1'b0;
    endcase

    cnt_d    = cnt_q;
    done_d   = done_q;
    seen_d   = seen_q;
    digits_d = digits_q;
    blank_d  = blank_q;
    frame_d  = 1'b0;
    err_d    = clr_err_i ? 1'b0 : err_q;
    mark     = 1'b0;
    seen_nx  = seen_q | (4'b0001 << dig_k);
`ifdef SSEG_SQUARE_DECODE_EN
    sq_d     = sq_q;
`endif

    if (!pair_same) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (cap) begin
      done_d = 1'b1;
      if (one_lit) begin
        if (hex[4]) begin
          digits_d[{dig_k, 2'b00} +: 4] = hex[3:0];
          blank_d[dig_k] = 1'b0;
          mark = 1'b1;
`ifdef SSEG_SQUARE_DECODE_EN
          sq_d[{dig_k, 1'b0} +: 2] = 2'b00;
`endif
        end else if (sseg_q == 7'h7F) begin
          blank_d[dig_k] = 1'b1;
          mark = 1'b1;
`ifdef SSEG_SQUARE_DECODE_EN
          sq_d[{dig_k, 1'b0} +: 2] = 2'b00;
        end else if (sseg_q == 7'b0011100) begin
          sq_d[{dig_k, 1'b0} +: 2] = 2'b01;
          blank_d[dig_k] = 1'b0;
          mark = 1'b1;
        end else if (sseg_q == 7'b0100011) begin
          sq_d[{dig_k, 1'b0} +: 2] = 2'b10;
          blank_d[dig_k] = 1'b0;
          mark = 1'b1;
`endif
        end else begin
          err_d = 1'b1;
        end
      end else if (an_q != 4'hF) begin
        // Two or more anodes low at once is a driver fault.
        err_d = 1'b1;
      end
    end

    if (mark) begin
      if (seen_nx == 4'hF) begin
        frame_d = 1'b1;
        seen_d  = 4'h0;
      end else begin
        seen_d = seen_nx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      an_q     <= 4'hF;
      sseg_q   <= 7'h7F;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      seen_q   <= 4'h0;
      digits_q <= 16'h0000;
      blank_q  <= 4'hF;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef SSEG_SQUARE_DECODE_EN
      sq_q     <= 8'h00;
`endif
    end else begin
      an_q     <= an_i;
      sseg_q   <= sseg_i;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      seen_q   <= seen_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
`ifdef SSEG_SQUARE_DECODE_EN
      sq_q     <= sq_d;
`endif
    end
  end

  assign digits_o = digits_q;
  assign blank_o  = blank_q;
  assign frame_o  = frame_q;
  assign err_o    = err_q;
`ifdef SSEG_SQUARE_DECODE_EN
  assign sq_o     = sq_q;
`else
  assign sq_o     = 8'h00;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: scan capture, dwell filtering, errors,
// optional square glyphs and asynchronous reset mid-dwell.
module tb_sseg_scan_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  an_i = 4'hF;
  logic [6:0]  sseg_i = 7'h7F;
  logic        clr_err_i = 1'b0;
  logic [15:0] digits_o;
  logic [3:0]  blank_o;
  logic [7:0]  sq_o;
  logic        frame_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;
  int frame_cnt = 0;
  int frame_base;

  localparam logic [6:0] S_1 = 7'b1111001, S_2 = 7'b0100100, S_A = 7'b0001000;
  localparam logic [6:0] S_B = 7'b0000011, S_3 = 7'b0110000, S_4 = 7'b0011001;
  localparam logic [6:0] S_5 = 7'b0010010, S_6 = 7'b0000010, S_7 = 7'b1111000;
  localparam logic [6:0] S_0 = 7'b1000000, S_OFF = 7'h7F, S_UPSQ = 7'b0011100;

  sseg_scan_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .an_i(an_i), .sseg_i(sseg_i),
    .clr_err_i(clr_err_i), .digits_o(digits_o), .blank_o(blank_o),
    .sq_o(sq_o), .frame_o(frame_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (frame_o === 1'b1) frame_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running required done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_i = an;
    sseg_i = seg;
    edges(n);
  endtask

  initial begin
    edges(2);
    check("rst_digits", digits_o, 16'h0000);
    check("rst_blank", 16'(blank_o), 16'h000F);
    check("rst_sq", 16'(sq_o), 16'h0000);
    check("rst_frame", 16'(frame_o), 16'h0000);
    check("rst_err", 16'(err_o), 16'h0000);

    rst_i = 1'b0;
    show(4'hF, S_OFF, 20);
    check("idle_digits", digits_o, 16'h0000);
    check("idle_blank", 16'(blank_o), 16'h000F);
    check("idle_frame_cnt", 16'(frame_cnt), 16'h0000);
    check("idle_err", 16'(err_o), 16'h0000);

    // "12Ab" on digits 3..0
    show(4'b0111, S_1, 50);
    show(4'b1011, S_2, 50);
    show(4'b1101, S_A, 50);
    check("scan_partial", digits_o, 16'h12A0);
    frame_base = frame_cnt;
    show(4'b1110, S_B, 4);
    check("scan_e3_frame", 16'(frame_o), 16'h0000);
    check("scan_e3_digit0", digits_o, 16'h12A0);
    edges(1);
    check("scan_e4_frame", 16'(frame_o), 16'h0001);
    check("scan_e4_digits", digits_o, 16'h12AB);
    check("scan_e4_blank", 16'(blank_o), 16'h0000);
    edges(45);
    check("scan_one_frame", 16'(frame_cnt - frame_base), 16'h0001);
    check("scan_err", 16'(err_o), 16'h0000);

    // too-short dwell is ignored
    show(4'b1110, S_5, 3);
    show(4'b1110, S_B, 10);
    check("short_dwell", digits_o, 16'h12AB);
    check("short_err", 16'(err_o), 16'h0000);
    show(4'b1110, S_7, 10);
    check("recapture_7", digits_o, 16'h12A7);
    show(4'b1101, S_OFF, 10);
    check("blank_digit1", 16'(blank_o), 16'h0002);
    check("blank_hold", digits_o, 16'h12A7);

    // two anodes low
    show(4'b1100, S_0, 4);
    check("multi_e3_err", 16'(err_o), 16'h0000);
    edges(1);
    check("multi_e4_err", 16'(err_o), 16'h0001);
    edges(5);
    check("multi_noupd", digits_o, 16'h12A7);
    clr_err_i = 1'b1;
    show(4'hF, S_OFF, 1);
    clr_err_i = 1'b0;
    check("clr_err", 16'(err_o), 16'h0000);
    show(4'b1100, S_0, 4);
    clr_err_i = 1'b1;
    edges(1);
    clr_err_i = 1'b0;
    check("set_beats_clr", 16'(err_o), 16'h0001);
    clr_err_i = 1'b1;
    show(4'hF, S_OFF, 1);
    clr_err_i = 1'b0;
    check("clr_err2", 16'(err_o), 16'h0000);

    // upper square on digit 2
    show(4'b1011, S_UPSQ, 10);
`ifdef SSEG_SQUARE_DECODE_EN
    check("sq_code", 16'(sq_o), 16'h0010);
    check("sq_err", 16'(err_o), 16'h0000);
`else
    check("sq_code", 16'(sq_o), 16'h0000);
    check("sq_err", 16'(err_o), 16'h0001);
`endif
    check("sq_blank", 16'(blank_o), 16'h0002);
    check("sq_digits", digits_o, 16'h12A7);
    clr_err_i = 1'b1;
    show(4'hF, S_OFF, 1);
    clr_err_i = 1'b0;

    // reset mid-dwell after three digits seen
    show(4'b0111, S_1, 10);
    show(4'b1011, S_2, 10);
    show(4'b1101, S_A, 10);
    show(4'b1110, S_B, 3);
    rst_i = 1'b1;
    #1;
    check("mid_rst_digits", digits_o, 16'h0000);
    check("mid_rst_blank", 16'(blank_o), 16'h000F);
    check("mid_rst_sq", 16'(sq_o), 16'h0000);
    check("mid_rst_err", 16'(err_o), 16'h0000);
    edges(1);
    rst_i = 1'b0;
    frame_base = frame_cnt;
    show(4'b0111, S_3, 10);
    show(4'b1011, S_4, 10);
    show(4'b1101, S_5, 10);
    show(4'b1110, S_6, 10);
    show(4'hF, S_OFF, 10);
    check("post_rst_digits", digits_o, 16'h3456);
    check("post_rst_blank", 16'(blank_o), 16'h0000);
    check("post_rst_frames", 16'(frame_cnt - frame_base), 16'h0001);
    check("post_rst_err", 16'(err_o), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
